// File: rtl/pkg_imageCache.sv
// Image cache geometry defaults and the unloader's FSM state type.
package pkg_imageCache;

  localparam int IC_ADDR_WIDTH = 10;
  localparam int IC_ROW_WIDTH  = 5;
  localparam int IC_COL_WIDTH  = 5;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } unl_state_e;

endpackage

// File: rtl/structs.sv
// Cache read request; coordinate fields are sized for the largest supported frame.
package structs;

  typedef struct packed {
    logic                                     re;
    logic [pkg_imageCache::IC_COL_WIDTH-1:0]  raddrX;
    logic [pkg_imageCache::IC_ROW_WIDTH-1:0]  raddrY;
  } struct_imageCache_Read;

endpackage

// File: rtl/image_cache_unloader_if.sv
// Cache read port and output stream of the image cache unloader.
// IMAGE_CACHE_UNLOADER_LAST_EN adds the end-of-frame marker.
interface image_cache_unloader_if #(
  parameter int WORD_SIZE = 32
);
  import structs::*;

  struct_imageCache_Read  icr;
  logic [WORD_SIZE-1:0]   rdata;
  logic [WORD_SIZE-1:0]   data;
  logic                   data_ready;
  logic                   data_wanted;
`ifdef IMAGE_CACHE_UNLOADER_LAST_EN
  logic                   last;
`endif

  modport master (
    output icr, data, data_ready,
`ifdef IMAGE_CACHE_UNLOADER_LAST_EN
    output last,
`endif
    input  rdata, data_wanted
  );

  modport slave (
    input  icr, data, data_ready,
`ifdef IMAGE_CACHE_UNLOADER_LAST_EN
    input  last,
`endif
    output rdata, data_wanted
  );

endinterface

// File: rtl/image_cache_skid_fifo.sv
// Two-entry FIFO holding returned words the consumer has not yet accepted.
module image_cache_skid_fifo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ do_push;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/image_cache_unloader.sv
// Streams one frame out of the image cache in raster order through a two-entry buffer.
// Define IMAGE_CACHE_UNLOADER_LAST_EN to drive bus.last on the final word.
module image_cache_unloader
  import pkg_imageCache::*;
  import structs::*;
#(
  parameter int ADDR_WIDTH = IC_ADDR_WIDTH,
  parameter int WORD_SIZE  = 32,
  parameter int ROW_WIDTH  = IC_ROW_WIDTH,
  parameter int COL_WIDTH  = IC_COL_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  image_cache_unloader_if.master bus,
  output logic                   busy,
  output logic                   unloaded
);
  localparam int FRAME_BITS = ROW_WIDTH + COL_WIDTH;
  localparam logic [FRAME_BITS-1:0] LAST_ADDR = '1;

  if (COL_WIDTH > IC_COL_WIDTH || ROW_WIDTH > IC_ROW_WIDTH ||
      FRAME_BITS > ADDR_WIDTH) begin : g_bad_geometry
    $error("image_cache_unloader: frame geometry does not fit the cache read port");
  end

  // States: IDLE waits for start, READ issues reads, DRAIN empties the buffer.
  unl_state_e            state_q, state_d;
  logic [FRAME_BITS-1:0] addr_q, addr_d;
  logic                  inflight_q, unloaded_q, unloaded_d;
  logic                  rd_en, xfer, final_xfer;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [WORD_SIZE-1:0]  fifo_head;
  logic [1:0]            occupancy, pending;

  assign occupancy = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
  assign pending   = occupancy + {1'b0, inflight_q};

  // An empty buffer passes returning data straight through, giving 1 word/cycle.
  assign bus.data_ready = !fifo_empty || inflight_q;
  assign bus.data       = !fifo_empty ? fifo_head : (inflight_q ? bus.rdata : '0);
  assign xfer           = bus.data_ready && bus.data_wanted;
  assign fifo_pop       = xfer && !fifo_empty;
  assign fifo_push      = inflight_q && !(fifo_empty && xfer);
  assign final_xfer     = (state_q == DRAIN) && xfer && (pending == 2'd1);

  assign busy     = (state_q != IDLE);
  assign unloaded = unloaded_q;

`ifdef IMAGE_CACHE_UNLOADER_LAST_EN
  assign bus.last = (state_q == DRAIN) && (pending == 2'd1);
`endif

  image_cache_skid_fifo #(
    .WIDTH (WORD_SIZE)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (bus.rdata),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    unloaded_d = 1'b0;
    rd_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !unloaded_q) begin
          state_d = READ;
          addr_d  = '0;
        end
      end
      READ: begin
        if (pending < 2'd2) begin
          rd_en  = 1'b1;
          addr_d = addr_q + 1'b1;
          if (addr_q == LAST_ADDR) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (final_xfer) begin
          state_d    = IDLE;
          unloaded_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.icr                        = '0;
    bus.icr.re                     = rd_en;
    bus.icr.raddrX[COL_WIDTH-1:0]  = addr_q[COL_WIDTH-1:0];
    bus.icr.raddrY[ROW_WIDTH-1:0]  = addr_q[FRAME_BITS-1:COL_WIDTH];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      unloaded_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      inflight_q <= rd_en;
      unloaded_q <= unloaded_d;
    end
  end

endmodule

// File: tb/tb_image_cache_unloader.sv
// Scoreboard bench: each accepted start queues the frame's raster sequence; a monitor checks transfers.
module tb_image_cache_unloader;
  localparam int RW = 2;
  localparam int CW = 2;
  localparam int WS = 32;
  localparam int NW = 1 << (RW + CW);

  logic          clk = 1'b0;
  logic          reset, start, busy, unloaded;
  int            n_run = 0;
  int            n_fail = 0;
  logic [WS-1:0] exp_q [$];
  int            xfer_cnt = 0;
  int            re_cnt = 0;
  logic          unl_exp = 1'b0;
  logic          hold_q = 1'b0;
  logic [WS-1:0] hold_data = '0;

  image_cache_unloader_if #(.WORD_SIZE(WS)) bus ();

  image_cache_unloader #(
    .ADDR_WIDTH (10),
    .WORD_SIZE  (WS),
    .ROW_WIDTH  (RW),
    .COL_WIDTH  (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .busy     (busy),
    .unloaded (unloaded)
  );

  always #5 clk = ~clk;

  // Cache model: word = 16*Y + X, returned one cycle after the request; garbage otherwise.
  always @(posedge clk or posedge reset)
    if (reset) bus.rdata <= '0;
    else if (bus.icr.re) bus.rdata <= WS'(16 * int'(bus.icr.raddrY) + int'(bus.icr.raddrX));
    else bus.rdata <= 32'hDEAD_BEEF;

  task automatic check(input string name, input logic [WS-1:0] act, input logic [WS-1:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    for (int y = 0; y < (1 << RW); y++)
      for (int x = 0; x < (1 << CW); x++)
        exp_q.push_back(WS'(16 * y + x));
  endtask

  task automatic start_frame();
    start  = 1'b1;
    re_cnt = 0;
    push_frame();
    step();
    start = 1'b0;
  endtask

  task automatic drive_wanted(input int mode, input int cyc);
    case (mode)
      0:       bus.data_wanted = 1'b1;
      1:       bus.data_wanted = (cyc % 2) == 1;
      default: bus.data_wanted = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic finish_frame(input int mode, input bit pulse_mid, input bit start_on_unl);
    int cyc = 0;
    bit pulsed = 1'b0;
    while (exp_q.size() != 0 && cyc < 400) begin
      drive_wanted(mode, cyc);
      start = 1'b0;
      if (pulse_mid && !pulsed && (NW - exp_q.size()) == 5) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end else if (mode == 2 && exp_q.size() > 1 && $urandom_range(0, 7) == 0) begin
        start = 1'b1;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    if (exp_q.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL frame_timeout: got %0d words outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    bus.data_wanted = 1'b1;
    if (start_on_unl) begin
      check("unloaded_cycle", 32'(unloaded), 32'd1);
      start = 1'b1;
    end
    step();
    start = 1'b0;
    step();
    step();
    check("reads_per_frame", WS'(re_cnt), WS'(NW));
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_re"},         32'(bus.icr.re),      32'd0);
    check({tag, "_data_ready"}, 32'(bus.data_ready),  32'd0);
    check({tag, "_busy"},       32'(busy),            32'd0);
    check({tag, "_unloaded"},   32'(unloaded),        32'd0);
    check({tag, "_data"},       bus.data,             32'd0);
`ifdef IMAGE_CACHE_UNLOADER_LAST_EN
    check({tag, "_last"},       32'(bus.last),        32'd0);
`endif
  endtask

  task automatic monitor();
    logic [WS-1:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        xfer_cnt = 0;
        unl_exp  = 1'b0;
        hold_q   = 1'b0;
        continue;
      end
      check("unloaded", 32'(unloaded), 32'(unl_exp));
      unl_exp = 1'b0;
      if (hold_q) begin
        check("hold_ready", 32'(bus.data_ready), 32'd1);
        check("hold_data", bus.data, hold_data);
      end
`ifdef IMAGE_CACHE_UNLOADER_LAST_EN
      if (bus.data_ready) check("last", 32'(bus.last), 32'(xfer_cnt == NW - 1));
`endif
      if (bus.icr.re) re_cnt++;
      if (bus.data_ready && bus.data_wanted) begin
        if (exp_q.size() == 0) begin
          n_run++;
          n_fail++;
          $display("FAIL extra_word: got 0x%0h, expected no transfer", bus.data);
        end else begin
          e = exp_q.pop_front();
          check("data", bus.data, e);
          xfer_cnt++;
          if (xfer_cnt == NW) begin
            xfer_cnt = 0;
            unl_exp  = 1'b1;
          end
        end
      end
      hold_q    = bus.data_ready && !bus.data_wanted;
      hold_data = bus.data;
    end
  endtask

  initial begin
    reset           = 1'b1;
    start           = 1'b0;
    bus.data_wanted = 1'b0;
    fork
      monitor();
      begin
        #2;
        check_outputs_zero("reset");
        step();
        #2 reset = 1'b0;
        step();

        // Full-speed frame: latency and throughput.
        bus.data_wanted = 1'b1;
        start  = 1'b1;
        re_cnt = 0;
        push_frame();
        check("lat_c0_ready", 32'(bus.data_ready), 32'd0);
        step();
        start = 1'b0;
        check("lat_c1_re",    32'(bus.icr.re),     32'd1);
        check("lat_c1_x",     32'(bus.icr.raddrX), 32'd0);
        check("lat_c1_y",     32'(bus.icr.raddrY), 32'd0);
        check("lat_c1_ready", 32'(bus.data_ready), 32'd0);
        check("lat_c1_busy",  32'(busy),           32'd1);
        step();
        check("lat_c2_ready", 32'(bus.data_ready), 32'd1);
        check("lat_c2_data",  bus.data,            32'h00);
        repeat (15) step();
        check("throughput", 32'(exp_q.size()), 32'd1);
        finish_frame(0, 1'b0, 1'b0);

        // Toggling consumer.
        start_frame();
        finish_frame(1, 1'b0, 1'b0);

        // Consumer stalled for 10 cycles.
        bus.data_wanted = 1'b0;
        start_frame();
        repeat (9) step();
        check("stall_reads", WS'(re_cnt),          WS'(2));
        check("stall_ready", 32'(bus.data_ready),  32'd1);
        check("stall_data",  bus.data,             32'h00);
        finish_frame(0, 1'b0, 1'b0);

        // Start at word 5 and in the unloaded cycle are ignored; then a fresh frame.
        start_frame();
        finish_frame(2, 1'b1, 1'b1);
        start_frame();
        finish_frame(0, 1'b0, 1'b0);

        // Reset mid-frame at word 7.
        bus.data_wanted = 1'b1;
        start_frame();
        for (int i = 0; i < 100 && (NW - exp_q.size()) < 7; i++) step();
        check("reach_word7", 32'(NW - exp_q.size()), 32'd7);
        #2 reset = 1'b1;
        #1;
        check_outputs_zero("midreset");
        exp_q.delete();
        step();
        step();
        #2 reset = 1'b0;
        step();
        start_frame();
        finish_frame(2, 1'b0, 1'b0);

        // Randomized consumer with stray starts while busy.
        for (int f = 0; f < 3; f++) begin
          start_frame();
          finish_frame(2, 1'b0, 1'b0);
        end
      end
    join_any
    disable fork;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
